// File: rtl/nibble_unpacker_pkg.sv
// nibble_unpacker_pkg: shared sizing constants and FSM state type for the
// nibble unpacker and its register-file store.
package nibble_unpacker_pkg;

   localparam int unsigned NIBBLES    = 16;
   localparam int unsigned W          = 4;
   localparam int unsigned FRAME_BITS = NIBBLES * W;
   localparam int unsigned BCNT_W     = $clog2(FRAME_BITS);
   localparam int unsigned IDX_W      = $clog2(NIBBLES);
   localparam int unsigned CNT_W      = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

endpackage

// File: rtl/nibble_store.sv
// nibble_store: NIBBLES x W register file, one write port and one registered
// read port. Reading an address in the same cycle it is written returns the
// previous contents.
// Ports:
//   clk, rst         clock, asynchronous active-high reset (clears contents)
//   we, waddr, wdata write port
//   raddr, rdata     read address, registered read data (1-cycle latency)
module nibble_store
   import nibble_unpacker_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [IDX_W-1:0] waddr,
   input  logic [W-1:0]     wdata,
   input  logic [IDX_W-1:0] raddr,
   output logic [W-1:0]     rdata
);

   logic [W-1:0] mem_q [NIBBLES];
   logic [W-1:0] mem_d [NIBBLES];
   logic [W-1:0] rdata_q;
   logic [W-1:0] rdata_d;

   // Next contents and read data; read uses pre-write contents.
   always_comb begin
      mem_d   = mem_q;
      rdata_d = mem_q[raddr];
      if (we) begin
         mem_d[waddr] = wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q   <= '{default: '0};
         rdata_q <= '0;
      end else begin
         mem_q   <= mem_d;
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/nibble_unpacker.sv
// nibble_unpacker: reassembles an LSB-first serial stream of NIBBLES x W-bit
// nibbles, stores each frame in a register file and reports nibbles, frame
// completion and a frame counter. Runs back-to-back frames once started; only
// rst returns it to IDLE.
// Optional feature: define CHECKSUM_EN to build the per-frame XOR checksum on
// chk/chk_valid; otherwise both are tied to zero.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   ena                 start strobe (sampled in IDLE only)
//   data_in             serial input bit
//   nib_out/nib_idx     last assembled nibble and its index
//   nib_valid           one-cycle pulse per assembled nibble
//   frame_done          one-cycle pulse with the last nibble of a frame
//   frame_cnt           completed frames, saturating
//   busy                high while in SHIFT
//   rd_addr, rd_data    store read port (1-cycle latency)
//   chk, chk_valid      frame XOR checksum and its pulse
module nibble_unpacker
   import nibble_unpacker_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             data_in,
   output logic [W-1:0]     nib_out,
   output logic             nib_valid,
   output logic [IDX_W-1:0] nib_idx,
   output logic             frame_done,
   output logic [CNT_W-1:0] frame_cnt,
   output logic             busy,
   input  logic [IDX_W-1:0] rd_addr,
   output logic [W-1:0]     rd_data,
   output logic [W-1:0]     chk,
   output logic             chk_valid
);

   state_e state_q, state_d;

   logic [BCNT_W-1:0] bcnt_q, bcnt_d;
   logic [W-2:0]      sh_q, sh_d;
   logic [W-1:0]      nib_out_q, nib_out_d;
   logic              nib_valid_q, nib_valid_d;
   logic [IDX_W-1:0]  nib_idx_q, nib_idx_d;
   logic              frame_done_q, frame_done_d;
   logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
   logic              busy_q, busy_d;

   logic              shifting_c;
   logic              nib_last_c;
   logic              frame_last_c;
   logic [W-1:0]      nib_asm_c;
   logic [IDX_W-1:0]  cur_idx_c;
   logic              store_we_c;

   assign shifting_c   = (state_q == SHIFT);
   assign nib_last_c   = shifting_c && (bcnt_q[1:0] == 2'd3);
   assign frame_last_c = shifting_c && (bcnt_q == BCNT_W'(FRAME_BITS - 1));
   assign nib_asm_c    = {data_in, sh_q};
   assign cur_idx_c    = bcnt_q[BCNT_W-1:2];
   assign store_we_c   = nib_last_c;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: SHIFT is sticky; ena only matters in IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (ena) state_d = SHIFT;
         SHIFT:   state_d = SHIFT;
         default: state_d = IDLE;
      endcase
   end

   // Datapath and registered-output next values.
   always_comb begin
      bcnt_d       = bcnt_q;
      sh_d         = sh_q;
      nib_out_d    = nib_out_q;
      nib_valid_d  = 1'b0;
      nib_idx_d    = nib_idx_q;
      frame_done_d = 1'b0;
      frame_cnt_d  = frame_cnt_q;
      busy_d       = (state_d == SHIFT);

      if (!shifting_c) begin
         // Hold counter and shifter cleared so SHIFT starts at bit 0.
         bcnt_d = '0;
         sh_d   = '0;
      end else begin
         // Counter wraps naturally 63->0 for back-to-back frames.
         bcnt_d = BCNT_W'(bcnt_q + 1'b1);
         sh_d   = {data_in, sh_q[W-2:1]};
         if (nib_last_c) begin
            nib_out_d   = nib_asm_c;
            nib_idx_d   = cur_idx_c;
            nib_valid_d = 1'b1;
         end
         if (frame_last_c) begin
            frame_done_d = 1'b1;
            if (frame_cnt_q != '1) begin
               frame_cnt_d = CNT_W'(frame_cnt_q + 1'b1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bcnt_q       <= '0;
         sh_q         <= '0;
         nib_out_q    <= '0;
         nib_valid_q  <= 1'b0;
         nib_idx_q    <= '0;
         frame_done_q <= 1'b0;
         frame_cnt_q  <= '0;
         busy_q       <= 1'b0;
      end else begin
         bcnt_q       <= bcnt_d;
         sh_q         <= sh_d;
         nib_out_q    <= nib_out_d;
         nib_valid_q  <= nib_valid_d;
         nib_idx_q    <= nib_idx_d;
         frame_done_q <= frame_done_d;
         frame_cnt_q  <= frame_cnt_d;
         busy_q       <= busy_d;
      end
   end

   nibble_store u_store (
      .clk   (clk),
      .rst   (rst),
      .we    (store_we_c),
      .waddr (cur_idx_c),
      .wdata (nib_asm_c),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

`ifdef CHECKSUM_EN
   logic [W-1:0] acc_q, acc_d;
   logic [W-1:0] chk_q, chk_d;
   logic         chk_valid_q, chk_valid_d;
   logic [W-1:0] acc_next_c;

   assign acc_next_c = acc_q ^ nib_asm_c;

   // Running XOR; published and cleared on the last nibble of a frame.
   always_comb begin
      acc_d       = acc_q;
      chk_d       = chk_q;
      chk_valid_d = 1'b0;
      if (nib_last_c) begin
         acc_d = acc_next_c;
      end
      if (frame_last_c) begin
         chk_d       = acc_next_c;
         chk_valid_d = 1'b1;
         acc_d       = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q       <= '0;
         chk_q       <= '0;
         chk_valid_q <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         chk_q       <= chk_d;
         chk_valid_q <= chk_valid_d;
      end
   end

   assign chk       = chk_q;
   assign chk_valid = chk_valid_q;
`else
   assign chk       = '0;
   assign chk_valid = 1'b0;
`endif

   assign nib_out    = nib_out_q;
   assign nib_valid  = nib_valid_q;
   assign nib_idx    = nib_idx_q;
   assign frame_done = frame_done_q;
   assign frame_cnt  = frame_cnt_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_nibble_unpacker.sv
// tb_nibble_unpacker: directed + randomized bench for nibble_unpacker. The
// upstream buffer is modelled as a queue of nibbles shifted out LSB first;
// expectations come from frame arithmetic on the cycle count since start.
module tb_nibble_unpacker;

   logic       clk = 1'b0;
   logic       rst;
   logic       ena;
   logic       data_in;
   logic [3:0] nib_out;
   logic       nib_valid;
   logic [3:0] nib_idx;
   logic       frame_done;
   logic [7:0] frame_cnt;
   logic       busy;
   logic [3:0] rd_addr;
   logic [3:0] rd_data;
   logic [3:0] chk;
   logic       chk_valid;

   int n_checks = 0;
   int n_fail   = 0;

   logic [3:0] src [$];
   logic [3:0] mem_m [16];
   logic [3:0] exp_chk;

   nibble_unpacker dut (
      .clk        (clk),
      .rst        (rst),
      .ena        (ena),
      .data_in    (data_in),
      .nib_out    (nib_out),
      .nib_valid  (nib_valid),
      .nib_idx    (nib_idx),
      .frame_done (frame_done),
      .frame_cnt  (frame_cnt),
      .busy       (busy),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .chk        (chk),
      .chk_valid  (chk_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " nib_out"},    32'(nib_out),    32'd0);
      check({tag, " nib_valid"},  32'(nib_valid),  32'd0);
      check({tag, " nib_idx"},    32'(nib_idx),    32'd0);
      check({tag, " frame_done"}, 32'(frame_done), 32'd0);
      check({tag, " frame_cnt"},  32'(frame_cnt),  32'd0);
      check({tag, " busy"},       32'(busy),       32'd0);
      check({tag, " rd_data"},    32'(rd_data),    32'd0);
      check({tag, " chk"},        32'(chk),        32'd0);
      check({tag, " chk_valid"},  32'(chk_valid),  32'd0);
   endtask

   // Start with ena, then stream ncyc bits from src and check every cycle.
   task automatic run(input int ncyc);
      int         t;
      int         f;
      int         ecnt;
      logic [3:0] nb;
      logic [3:0] exp_rd;
      logic [3:0] x;
      ena     = 1'b1;
      data_in = 1'b0;
      rd_addr = 4'($urandom);
      @(posedge clk);
      t      = 0;
      exp_rd = mem_m[rd_addr];
      @(negedge clk);
      check("start busy", 32'(busy), 32'd1);
      check("start nib_valid", 32'(nib_valid), 32'd0);
      check("start rd_data", 32'(rd_data), 32'(exp_rd));
      for (int k = 0; k < ncyc; k++) begin
         nb      = src[t / 4];
         data_in = nb[t % 4];
         // ena held high for a while mid-frame must be ignored
         ena     = (t >= 10 && t < 20);
         if (t + 1 == 70)      rd_addr = 4'd5;
         else if (t + 1 == 80) rd_addr = 4'd3;
         else                  rd_addr = 4'($urandom);
         @(posedge clk);
         t++;
         exp_rd = mem_m[rd_addr];
         if (t % 4 == 0) mem_m[(t / 4 - 1) % 16] = src[t / 4 - 1];
         if (t % 64 == 0) begin
            f = t / 64 - 1;
            x = 4'd0;
            for (int i = 0; i < 16; i++) x = x ^ src[16 * f + i];
            exp_chk = x;
         end
         ecnt = (t / 64 > 255) ? 255 : t / 64;
         @(negedge clk);
         check("nib_valid", 32'(nib_valid), 32'(t % 4 == 0));
         if (t % 4 == 0) begin
            check("nib_out", 32'(nib_out), 32'(src[t / 4 - 1]));
            check("nib_idx", 32'(nib_idx), 32'((t / 4 - 1) % 16));
         end
         check("frame_done", 32'(frame_done), 32'(t % 64 == 0));
         check("frame_cnt", 32'(frame_cnt), 32'(ecnt));
         check("busy", 32'(busy), 32'd1);
         check("rd_data", 32'(rd_data), 32'(exp_rd));
`ifdef CHECKSUM_EN
         check("chk_valid", 32'(chk_valid), 32'(t % 64 == 0));
         check("chk", 32'(chk), 32'(exp_chk));
`else
         check("chk_valid", 32'(chk_valid), 32'd0);
         check("chk", 32'(chk), 32'd0);
`endif
      end
   endtask

   initial begin
      rst     = 1'b1;
      ena     = 1'b0;
      data_in = 1'b0;
      rd_addr = 4'd0;
      exp_chk = 4'd0;
      foreach (mem_m[i]) mem_m[i] = 4'd0;

      #12;
      check_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      // IDLE without ena: nothing happens.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("idle nib_valid", 32'(nib_valid), 32'd0);
         check("idle busy", 32'(busy), 32'd0);
      end

      // Frame 1: 0..F; frame 2: 1 then zeros; then random frames.
      for (int i = 0; i < 16; i++) src.push_back(4'(i));
      src.push_back(4'd1);
      for (int i = 0; i < 15; i++) src.push_back(4'd0);
      for (int i = 0; i < 40; i++) src.push_back(4'($urandom));
      run(222);

      // Asynchronous reset mid-frame clears everything immediately.
      rst = 1'b1;
      #1;
      check_all_zero("midrst");
      @(negedge clk);
      rst = 1'b0;
      foreach (mem_m[i]) mem_m[i] = 4'd0;
      exp_chk = 4'd0;
      for (int a = 0; a < 16; a++) begin
         rd_addr = 4'(a);
         @(posedge clk);
         @(negedge clk);
         check("cleared store", 32'(rd_data), 32'd0);
         check("post-rst busy", 32'(busy), 32'd0);
         check("post-rst nib_valid", 32'(nib_valid), 32'd0);
      end

      // Restart with fresh random data.
      src.delete();
      for (int i = 0; i < 24; i++) src.push_back(4'($urandom));
      run(68);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
